// File: rtl/lynx_tape_encoder.sv
// Cassette transmitter: serialises a valid/ready byte stream into the square-wave ear level.
// Optional trailing checksum byte enabled by defining LYNX_TAPE_CHECKSUM_EN.
module lynx_tape_encoder #(
    parameter int unsigned ZERO_HALF   = 8,
    parameter int unsigned ONE_HALF    = 4,
    parameter int unsigned LEADER_BITS = 64,
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
    parameter int unsigned TRAIL_BITS  = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ce,
    input  logic       motor,
    input  logic       start,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output logic       ear,
    output logic       busy,
    output logic       done,
    output logic       underrun
);

    localparam int unsigned HalfMax = (ZERO_HALF > ONE_HALF) ? ZERO_HALF : ONE_HALF;
    localparam int unsigned TW      = $clog2(2 * HalfMax);
    localparam int unsigned BitsLT  = (LEADER_BITS > TRAIL_BITS) ? LEADER_BITS : TRAIL_BITS;
    localparam int unsigned BitsMax = (BitsLT > 8) ? BitsLT : 8;
    localparam int unsigned BW      = $clog2(BitsMax);

    typedef enum logic [2:0] {
        StIdle,
        StLeader,
        StSync,
        StData,
        StStall,
        StTrail
`ifdef LYNX_TAPE_CHECKSUM_EN
        , StCksum
`endif
    } state_e;

    state_e          state_q, state_d;
    logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
    logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            shift_last_q, shift_last_d;
    logic [7:0]      buf_q, buf_d;
    logic            buf_last_q, buf_last_d;
    logic            buf_full_q, buf_full_d;
    logic            ear_q, ear_d;
    logic            underrun_q, underrun_d;
    logic            done_q, done_d;
`ifdef LYNX_TAPE_CHECKSUM_EN
    logic [7:0]      sum_q, sum_d;
`endif

    logic            tick;
    logic            cur_bit;
    int unsigned     half;
    logic [BW-1:0]   bit_last;
    logic            bit_end;
    logic            seq_end;
    logic            do_load;

    assign tick     = ce & motor;
    assign busy     = (state_q != StIdle);
    assign in_ready = busy & ~buf_full_q;
    assign ear      = ear_q;
    assign done     = done_q;
    assign underrun = underrun_q;

    // Leader and trailer cells are always zero bits; every other bit comes off the shifter.
    always_comb begin
        cur_bit  = 1'b0;
        bit_last = BW'(7);
        case (state_q)
            StLeader: bit_last = BW'(LEADER_BITS - 1);
            StTrail:  bit_last = BW'(TRAIL_BITS - 1);
            StSync, StData: cur_bit = shift_q[7];
`ifdef LYNX_TAPE_CHECKSUM_EN
            StCksum: cur_bit = shift_q[7];
`endif
            default: ;
        endcase
        half = cur_bit ? ONE_HALF : ZERO_HALF;
    end

    assign bit_end = (tick_cnt_q == TW'(2 * half - 1));
    assign seq_end = bit_end && (bit_cnt_q == bit_last);

    always_comb begin
        state_d      = state_q;
        tick_cnt_d   = tick_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        shift_last_d = shift_last_q;
        buf_d        = buf_q;
        buf_last_d   = buf_last_q;
        buf_full_d   = buf_full_q;
        ear_d        = ear_q;
        underrun_d   = underrun_q;
        done_d       = 1'b0;
        do_load      = 1'b0;
`ifdef LYNX_TAPE_CHECKSUM_EN
        sum_d        = sum_q;
`endif

        if (in_valid && in_ready) begin
            buf_d      = in_data;
            buf_last_d = in_last;
            buf_full_d = 1'b1;
        end

        case (state_q)
            StIdle: begin
                ear_d = 1'b0;
                if (start) begin
                    state_d    = StLeader;
                    tick_cnt_d = '0;
                    bit_cnt_d  = '0;
                    underrun_d = 1'b0;
`ifdef LYNX_TAPE_CHECKSUM_EN
                    sum_d      = 8'h00;
`endif
                end
            end

            // A refilled buffer restarts the waveform on the very tick it is noticed.
            StStall: begin
                underrun_d = 1'b1;
                ear_d      = 1'b0;
                if (tick && buf_full_q) begin
                    do_load    = 1'b1;
                    state_d    = StData;
                    ear_d      = 1'b1;
                    tick_cnt_d = TW'(1);
                    bit_cnt_d  = '0;
                end
            end

            default: begin
                if (tick) begin
                    ear_d = (32'(tick_cnt_q) < half);
                    if (!bit_end) begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end else begin
                        tick_cnt_d = '0;
                        shift_d    = {shift_q[6:0], 1'b0};
                        if (!seq_end) begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end else begin
                            bit_cnt_d = '0;
                            case (state_q)
                                StLeader: begin
                                    state_d = StSync;
                                    shift_d = SYNC_BYTE;
                                end
                                StSync, StData: begin
                                    if (state_q == StData && shift_last_q) begin
`ifdef LYNX_TAPE_CHECKSUM_EN
                                        state_d      = StCksum;
                                        shift_d      = sum_q;
                                        shift_last_d = 1'b0;
`else
                                        state_d      = StTrail;
`endif
                                    end else if (buf_full_q) begin
                                        state_d = StData;
                                        do_load = 1'b1;
                                    end else begin
                                        state_d    = StStall;
                                        underrun_d = 1'b1;
                                    end
                                end
`ifdef LYNX_TAPE_CHECKSUM_EN
                                StCksum: state_d = StTrail;
`endif
                                StTrail: begin
                                    state_d = StIdle;
                                    done_d  = 1'b1;
                                end
                                default: state_d = StIdle;
                            endcase
                        end
                    end
                end
            end
        endcase

        if (do_load) begin
            shift_d      = buf_q;
            shift_last_d = buf_last_q;
            buf_full_d   = 1'b0;
`ifdef LYNX_TAPE_CHECKSUM_EN
            sum_d        = sum_q + buf_q;
`endif
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            tick_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= 8'h00;
            shift_last_q <= 1'b0;
            buf_q        <= 8'h00;
            buf_last_q   <= 1'b0;
            buf_full_q   <= 1'b0;
            ear_q        <= 1'b0;
            underrun_q   <= 1'b0;
            done_q       <= 1'b0;
`ifdef LYNX_TAPE_CHECKSUM_EN
            sum_q        <= 8'h00;
`endif
        end else begin
            state_q      <= state_d;
            tick_cnt_q   <= tick_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            shift_last_q <= shift_last_d;
            buf_q        <= buf_d;
            buf_last_q   <= buf_last_d;
            buf_full_q   <= buf_full_d;
            ear_q        <= ear_d;
            underrun_q   <= underrun_d;
            done_q       <= done_d;
`ifdef LYNX_TAPE_CHECKSUM_EN
            sum_q        <= sum_d;
`endif
        end
    end

endmodule

// File: tb/tb_lynx_tape_encoder.sv
// Directed bench for lynx_tape_encoder: records ear on every motor-enabled ce tick and
// compares against a bit-cell waveform built from the block contents.
module tb_lynx_tape_encoder;

    localparam int ZH = 8;
    localparam int OH = 4;
`ifdef LYNX_TAPE_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       ce = 1'b0;
    logic       motor = 1'b1;
    logic       start = 1'b0;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_last;
    logic       in_ready, ear, busy, done, underrun;

    lynx_tape_encoder dut (
        .clock    (clock),
        .reset    (reset),
        .ce       (ce),
        .motor    (motor),
        .start    (start),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_last  (in_last),
        .in_ready (in_ready),
        .ear      (ear),
        .busy     (busy),
        .done     (done),
        .underrun (underrun)
    );

    typedef struct {
        logic [7:0] d;
        logic       last;
    } src_t;

    typedef struct {
        logic [7:0] d0;
        logic [7:0] d1;
        int         n;
        int         exp_ticks;
        bit         poke;
        bit         pause;
    } vec_t;

    src_t src_q[$];
    bit   ear_q[$];
    bit   exp_q[$];
    vec_t vt[4];

    int   nvec = 0;
    int   nfail = 0;
    int   done_cnt = 0;
    int   busy_bad = 0;
    int   last_acc_idx = 0;
    bit   rec = 1'b0;
    bit   hold = 1'b0;
    bit   acc;
    bit   tick_s;

    always #5 clock = ~clock;

    // ce: one clock in every four
    initial begin
        int cnt = 0;
        forever begin
            @(negedge clock);
            ce = (cnt == 3);
            cnt = (cnt + 1) % 4;
        end
    end

    always begin
        @(posedge clock);
        tick_s = ce & motor;
        #1;
        if (rec && tick_s) ear_q.push_back(ear);
        if (done) begin
            done_cnt++;
            if (busy) busy_bad++;
        end
    end

    // Byte source: keeps presenting the queue head, so it also offers data while the buffer is full.
    initial begin
        in_valid = 1'b0;
        in_data  = 8'h00;
        in_last  = 1'b0;
        forever begin
            @(posedge clock);
            acc = in_valid && in_ready;
            @(negedge clock);
            if (acc && src_q.size() > 0) begin
                src_q.delete(0);
                last_acc_idx = ear_q.size();
            end
            if (src_q.size() > 0 && !hold) begin
                in_valid = 1'b1;
                in_data  = src_q[0].d;
                in_last  = src_q[0].last;
            end else begin
                in_valid = 1'b0;
            end
        end
    end

    task automatic check(input string nm, input int act, input int req);
        nvec++;
        if (act != req) begin
            nfail++;
            $display("FAIL %s: got %0d, required %0d", nm, act, req);
        end
    endtask

    function automatic void emit_bit(input bit b);
        int h = b ? OH : ZH;
        repeat (h) exp_q.push_back(1'b1);
        repeat (h) exp_q.push_back(1'b0);
    endfunction

    function automatic void emit_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) emit_bit(v[i]);
    endfunction

    function automatic void emit_head();
        exp_q.delete();
        repeat (64) emit_bit(1'b0);
        emit_byte(8'hA5);
    endfunction

    function automatic void emit_tail(input logic [7:0] sum);
        if (CK) emit_byte(sum);
        repeat (16) emit_bit(1'b0);
    endfunction

    task automatic check_seq(input string nm);
        int bad = -1;
        for (int i = 0; i < exp_q.size() && i < ear_q.size(); i++)
            if (bad < 0 && ear_q[i] != exp_q[i]) bad = i;
        if (bad < 0 && ear_q.size() != exp_q.size())
            bad = (ear_q.size() < exp_q.size()) ? ear_q.size() : exp_q.size();
        nvec++;
        if (bad >= 0) begin
            nfail++;
            $display("FAIL %s: waveform differs at tick %0d (got %0d ticks, required %0d ticks)",
                     nm, bad, ear_q.size(), exp_q.size());
        end
    endtask

    task automatic wait_size(input int n, input string nm);
        int k = 0;
        while (ear_q.size() < n && k < 20000) begin
            @(negedge clock);
            k++;
        end
        if (ear_q.size() < n) begin
            nvec++;
            nfail++;
            $display("FAIL %s timeout: ticks %0d, required %0d", nm, ear_q.size(), n);
        end
    endtask

    task automatic wait_done(input string nm);
        int k = 0;
        while (done_cnt == 0 && k < 12000) begin
            @(negedge clock);
            k++;
        end
        if (done_cnt == 0) begin
            nvec++;
            nfail++;
            $display("FAIL %s timeout: done never seen, ticks %0d", nm, ear_q.size());
        end
    endtask

    task automatic pulse_start();
        @(negedge clock);
        ear_q.delete();
        done_cnt = 0;
        busy_bad = 0;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        rec = 1'b1;
    endtask

    task automatic run_block(input int vi);
        vec_t       v = vt[vi];
        logic [7:0] sum = 8'h00;
        bit         paused = 1'b0;
        int         k = 0;
        src_q.push_back('{d: v.d0, last: (v.n == 1)});
        if (v.n == 2) src_q.push_back('{d: v.d1, last: 1'b1});
        pulse_start();
        while (done_cnt == 0 && k < 12000) begin
            @(negedge clock);
            k++;
            start = v.poke && (ear_q.size() == 500 || ear_q.size() == 1130);
            if (v.pause && !paused && ear_q.size() == 1140) begin
                logic fz = ear;
                int   bad = 0;
                int   sz0 = ear_q.size();
                paused = 1'b1;
                motor = 1'b0;
                repeat (50) begin
                    @(negedge clock);
                    if (ear != fz) bad++;
                end
                check($sformatf("v%0d_motor_ticks", vi), ear_q.size(), sz0);
                motor = 1'b1;
                check($sformatf("v%0d_motor_ear_frozen_errs", vi), bad, 0);
            end
        end
        start = 1'b0;
        if (done_cnt == 0) begin
            nvec++;
            nfail++;
            $display("FAIL v%0d timeout: done never seen, ticks %0d", vi, ear_q.size());
        end
        @(negedge clock);
        @(negedge clock);
        rec = 1'b0;
        emit_head();
        emit_byte(v.d0);
        sum = v.d0;
        if (v.n == 2) begin
            emit_byte(v.d1);
            sum = sum + v.d1;
        end
        emit_tail(sum);
        check($sformatf("v%0d_total_ticks", vi), ear_q.size(), v.exp_ticks);
        check_seq($sformatf("v%0d_waveform", vi));
        check($sformatf("v%0d_done_pulses", vi), done_cnt, 1);
        check($sformatf("v%0d_busy_with_done", vi), busy_bad, 0);
    endtask

    initial begin
        vt[0] = '{d0: 8'h00, d1: 8'hFF, n: 2, exp_ticks: CK ? 1632 : 1568, poke: 1, pause: 0};
        vt[1] = '{d0: 8'hA5, d1: 8'h5A, n: 2, exp_ticks: CK ? 1632 : 1568, poke: 0, pause: 1};
        vt[2] = '{d0: 8'hFF, d1: 8'h00, n: 1, exp_ticks: CK ? 1504 : 1440, poke: 0, pause: 0};
        vt[3] = '{d0: 8'h80, d1: 8'h00, n: 1, exp_ticks: CK ? 1616 : 1496, poke: 0, pause: 0};

        repeat (5) @(negedge clock);
        check("reset_ear", int'(ear), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_underrun", int'(underrun), 0);
        check("reset_in_ready", int'(in_ready), 0);
        reset = 1'b1;
        repeat (3) @(negedge clock);

        for (int i = 0; i < 4; i++) run_block(i);

        // Starved block: no data until 100 ticks after the sync byte.
        hold = 1'b1;
        src_q.push_back('{d: 8'h80, last: 1'b1});
        pulse_start();
        wait_size(1170, "stall_mid");
        check("stall_ear", int'(ear), 0);
        check("stall_underrun", int'(underrun), 1);
        wait_size(1220, "stall_end");
        hold = 1'b0;
        wait_done("stall_done");
        @(negedge clock);
        rec = 1'b0;
        emit_head();
        while (exp_q.size() < last_acc_idx) exp_q.push_back(1'b0);
        emit_byte(8'h80);
        emit_tail(8'h80);
        check("stall_first_high_after_accept",
              (last_acc_idx < ear_q.size()) ? int'(ear_q[last_acc_idx]) : -1, 1);
        check_seq("stall_waveform");
        check("stall_underrun_sticky", int'(underrun), 1);

        // Reset during a data byte that follows a stall.
        hold = 1'b1;
        src_q.push_back('{d: 8'h00, last: 1'b0});
        src_q.push_back('{d: 8'hFF, last: 1'b1});
        pulse_start();
        check("start_clears_underrun", int'(underrun), 0);
        wait_size(1140, "rst_stall");
        hold = 1'b0;
        begin
            int k = 0;
            while (src_q.size() > 1 && k < 200) begin
                @(negedge clock);
                k++;
            end
        end
        wait_size(last_acc_idx + 4, "rst_data");
        check("rst_pre_ear", int'(ear), 1);
        check("rst_pre_underrun", int'(underrun), 1);
        done_cnt = 0;
        #3 reset = 1'b0;
        #1;
        check("rst_async_ear", int'(ear), 0);
        check("rst_async_busy", int'(busy), 0);
        check("rst_async_in_ready", int'(in_ready), 0);
        check("rst_async_underrun", int'(underrun), 0);
        repeat (20) @(negedge clock);
        src_q.delete();
        hold = 1'b0;
        reset = 1'b1;
        repeat (100) @(negedge clock);
        check("rst_no_done", done_cnt, 0);
        rec = 1'b0;

        run_block(0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/lynx_tape_encoder.md
Name: lynx_tape_encoder

Overview:
- Cassette transmitter: serialises a byte stream into the square-wave level that the machine's tape-in (ear) path decodes.
- Feeds the ear input for audio playback of tape images, as an alternative to direct RAM injection. It can also drive an external tape-out.
- Sits between the tape-image byte source (valid/ready stream) and the ear/audio path. Timing is derived from a clock-enable tick.

Parameters:
- ZERO_HALF, 8: ce ticks per half-cycle of a 0 bit.
- ONE_HALF, 4: ce ticks per half-cycle of a 1 bit.
- LEADER_BITS, 64: number of 0 bits in the leader.
- SYNC_BYTE, 8'hA5: byte sent after the leader.
- TRAIL_BITS, 16: number of 0 bits after the final byte.

Ports:
- clock  in  1  system clock.
- reset  in  1  reset, asynchronous, active-low.
- ce  in  1  bit-timing tick enable, one clock wide.
- motor  in  1  1 = run, 0 = pause (all timing frozen).
- start  in  1  begin a block; sampled only in IDLE.
- in_data  in  8  byte to send.
- in_valid  in  1  in_data/in_last valid.
- in_last  in  1  marks final byte of the block.
- in_ready  out  1  holding buffer empty and busy.
- ear  out  1  encoded tape level.
- busy  out  1  state != IDLE.
- done  out  1  one-clock pulse at block completion.
- underrun  out  1  sticky: data starvation occurred; cleared by accepted start.

Behaviour:
- Reset (async, active-low): state IDLE, ear=0, busy=0, done=0, underrun=0, in_ready=0, holding buffer empty. Reset mid-block abandons the block with no done pulse.
- Registers update on posedge clock. Handshake acceptance happens on any clock; all waveform timing advances only on clocks with ce=1 and motor=1.
- With motor=0: counters, state and ear all frozen. The handshake still accepts into the buffer.
- Bit cell, value b, H = b ? ONE_HALF : ZERO_HALF:
  - ear=1 for H ce ticks, then ear=0 for H ce ticks; total 2H ticks.
  - The next bit starts on the tick after that, so there are no gaps between bits.
- Bytes are sent MSB first.
- Holding buffer (1 byte + last flag):
  - in_ready = busy & buffer empty.
  - Transfer occurs when in_valid & in_ready; the buffer then fills.
  - The shifter loads from the buffer at each data-byte boundary, emptying it.
- States:
  - IDLE: ear=0. start=1 → LEADER, clears underrun and counters. start in other states is ignored.
  - LEADER: sends LEADER_BITS 0 bits → SYNC. The first ce tick after start drives ear=1.
  - SYNC: sends SYNC_BYTE, then goes to DATA if the buffer is full, otherwise STALL.
  - DATA: sends the shifter byte. At the end of the byte:
    - if the byte was last → CKSUM (feature on) or TRAIL (feature off);
    - else if the buffer is full, load it and stay in DATA;
    - else → STALL.
  - STALL: ear=0, underrun=1. When the buffer fills, the next ce tick loads the shifter and goes to DATA, with ear=1 on that same tick.
  - TRAIL: sends TRAIL_BITS 0 bits → IDLE with done=1 for one clock; ear=0.
- Boundary conditions:
  - A byte accepted during LEADER/SYNC is held until the sync byte completes.
  - A byte with in_last=1 while the buffer is full is impossible (in_ready=0).
  - A block may be a single byte.
  - Counters are sized to their parameter; each bit counter wraps to 0 at byte end.

Optional Feature:
- Macro: LYNX_TAPE_CHECKSUM_EN.
- Defined:
  - An 8-bit modulo-256 sum of all data bytes (not the sync byte) is accumulated and cleared on start.
  - After the last data byte, state CKSUM sends the sum as one byte, then goes to TRAIL.
- Undefined: no accumulator and no CKSUM state; the last data byte goes directly to TRAIL.

Test Plan:
- Defaults, motor=1, ce every 4 clocks, start, bytes 8'h00 then 8'hFF(last):
  - ear=1 on the first ce after start;
  - leader = 64×16 ticks;
  - sync A5 bit pattern is 8/4 half-widths (1 bits 4-tick halves, 0 bits 8-tick halves);
  - total ticks = 1024 + 96 + 128 + 64 + 256 = 1568 (checksum off);
  - done pulses once; busy falls with it.
- Same stimulus with LYNX_TAPE_CHECKSUM_EN: checksum byte 8'hFF appended (64 ticks), total 1632 ticks.
- Hold in_valid=0 after sync for 100 ticks, then present 8'h80(last):
  - ear=0 and underrun=1 during the stall;
  - the first 4-tick high starts on the tick after acceptance;
  - underrun stays 1 until the next start.
- Drop motor for 50 clocks mid-data-bit: ear and remaining tick count unchanged; the waveform resumes exactly where it stopped.
- Assert reset mid-DATA: ear, busy, in_ready and underrun are 0 immediately (async); done never pulses; a following start produces a full leader.
- start pulsed while busy, and in_valid presented while the buffer is full: both ignored; byte order and count unchanged.
